ctrl_conv_stride: RTL
=====================

// Module: ctrl_conv_stride
// PURPOSE
//  Convolution controller with a rectangular image, a power-of-two stride and a parametrised pipeline delay.
//  Streams input pixels and flags every valid window (stride-decimated) to the feat-accum memory.
//  Scans the feature map back out in the OUTPUT phase.
//  Sits between the core FSM and the conv/accum datapath. Supersedes the fixed square, stride-1, 5-deep controller.
// PARAMETERS
//  LWIDTH  10  width of size/coordinate fields
//  FACCUM  10  feat-accum address width; address wraps modulo 2^FACCUM
//  PDELAY  5   datapath latency in cycles from window-valid stage to write; legal >=2
// PORTS
//  clk              in   1       clock
//  xrst             in   1       synchronous active-low reset
//  in_begin         in   1       start of layer; config sampled here
//  in_valid         in   1       input pixel accepted this cycle
//  in_end           in   1       end of input stream; ignored, interface compatibility only
//  core_state       in   2       0 WAIT, 1 WEIGHT, 2 INPUT, 3 OUTPUT; used combinationally
//  w_img_h/w_img_w  in   LWIDTH  image height/width
//  w_fil_size       in   LWIDTH  square filter size
//  w_stride_log2    in   2       stride = 1<<w_stride_log2; 3 is illegal
//  first_input      in   1       first input channel: accumulator reset on write
//  last_input       in   1       last input channel: arm out_begin
//  out_begin/out_valid/out_end  out  1  output stream framing
//  mem_feat_we      out  1       accum write enable
//  mem_feat_rst     out  1       write overwrites (no accumulate)
//  mem_feat_addr    out  FACCUM  read address, tap PDELAY-1
//  mem_feat_addr_d1 out  FACCUM  write address, tap PDELAY
//  conv_oe          out  1       datapath output enable, one cycle before out_valid
//  w_fea_h/w_fea_w  out  LWIDTH  latched feature size
//  cfg_err          out  1       one-cycle pulse on illegal config
// BEHAVIOUR
//  Reset: every output and register is 0; FSM goes to S_WAIT. Reset mid-operation aborts and clears all pipelines.
//  FSM: S_WAIT -> S_ACTIVE on in_begin with legal config. S_ACTIVE -> S_WAIT in the cycle out_end is 1.
//   in_begin while S_ACTIVE is ignored.
//  Config: legal iff fil!=0, fil<=img_h, fil<=img_w, stride_log2!=3. Illegal: stay S_WAIT, cfg_err=1 for 1 cycle.
//   Latch: fea_w=((img_w-fil)>>sl)+1, fea_h likewise; LWIDTH-bit unsigned arithmetic.
//  INPUT scan: x,y advance on in_valid when S_ACTIVE && core_state==2. x wraps at img_w-1, then y wraps at img_h-1.
//   Window valid: x>=fil-1 && y>=fil-1 && low sl bits of (x-fil+1) and (y-fil+1) are 0.
//  Latency: pixel accepted at cycle t -> stage0 flag at t+1.
//   mem_feat_we at t+1+PDELAY; mem_feat_rst = we && first_input (sampled at t).
//  Address counter: starts 0 per phase, +1 per stage0 window or output beat.
//   Cleared after the last input pixel and on out_end.
//   mem_feat_addr = counter delayed PDELAY-1; mem_feat_addr_d1 = delayed PDELAY.
//  out_begin: pulses at t+1+PDELAY for the last pixel (x=img_w-1, y=img_h-1) when last_input was 1.
//  OUTPUT scan: when S_ACTIVE && core_state==3 && !wait_back, one beat per cycle over fea_w x fea_h, row-major.
//   Beat at cycle t: conv_oe at t+PDELAY, out_valid at t+1+PDELAY; out_end with the final out_valid.
//  wait_back: set by the final beat; blocks further scanning and addressing until next in_begin.
//  in_valid gaps stall the scan only; pipelines keep flowing. in_valid outside INPUT is ignored.
// TESTING
//  h=w=6, fil=3, sl=0, first_input=1 -> fea 4x4; 16 we pulses, all with rst; mem_feat_addr_d1 0..15.
//   First we 1+PDELAY cycles after pixel (2,2).
//  h=5, w=7, fil=3, sl=1 -> fea_w=3, fea_h=2; we only for (x,y) in {2,4,6}x{2,4}; 6 writes, addr_d1 0..5.
//  fil=5, img 4x4 (also sl=3) -> cfg_err single pulse; state stays S_WAIT; no we; next legal in_begin accepted.
//  OUTPUT after 4x4 layer with last_input=1 -> out_begin once; 16 out_valid, conv_oe leads by 1.
//   out_end on 16th; then S_WAIT, no more beats while core_state stays 3.
//  Random in_valid gaps (50%) on 6x6 -> same 16 addresses/order. xrst=0 mid-INPUT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ctrl_conv_stride.sv
// Convolution controller: scans a rectangular image with a power-of-two stride,
// flags valid windows to the feat-accum memory and scans the feature map back out.
module ctrl_conv_stride #(
    parameter int LWIDTH = 10,
    parameter int FACCUM = 10,
    parameter int PDELAY = 5
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              in_begin,
    input  logic              in_valid,
    input  logic              in_end,
    input  logic [1:0]        core_state,
    input  logic [LWIDTH-1:0] w_img_h,
    input  logic [LWIDTH-1:0] w_img_w,
    input  logic [LWIDTH-1:0] w_fil_size,
    input  logic [1:0]        w_stride_log2,
    input  logic              first_input,
    input  logic              last_input,
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic              mem_feat_we,
    output logic              mem_feat_rst,
    output logic [FACCUM-1:0] mem_feat_addr,
    output logic [FACCUM-1:0] mem_feat_addr_d1,
    output logic              conv_oe,
    output logic [LWIDTH-1:0] w_fea_h,
    output logic [LWIDTH-1:0] w_fea_w,
    output logic              cfg_err
);

    typedef enum logic {S_WAIT = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [LWIDTH-1:0] L_ONE = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [FACCUM-1:0] F_ONE = {{(FACCUM-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [LWIDTH-1:0] r_img_h, r_img_w, r_fil, r_fea_h, r_fea_w;
    logic [1:0]        r_sl;
    logic [LWIDTH-1:0] r_x, r_y, r_ox, r_oy;
    logic              r_wait_back;
    logic [FACCUM-1:0] r_addr;

    logic              r_s0_win, r_s0_first, r_s0_last, r_s0_ob;
    logic [PDELAY:1]   r_we_pipe, r_rst_pipe, r_ob_pipe, r_oe_pipe, r_fin_pipe;
    logic [FACCUM-1:0] r_addr_pipe [PDELAY];

    logic              w_cfg_legal, w_start, w_accept, w_window;
    logic              w_x_last, w_y_last, w_last_pix;
    logic              w_beat, w_final_beat;
    logic [LWIDTH-1:0] w_fea_h_next, w_fea_w_next;
    logic [LWIDTH-1:0] w_fil_m1, w_dx, w_dy, w_sl_mask;
    logic              w_unused;

    assign w_unused = in_end;

    assign w_cfg_legal  = (w_fil_size != '0) && (w_fil_size <= w_img_h) &&
                          (w_fil_size <= w_img_w) && (w_stride_log2 != 2'd3);
    assign w_fea_h_next = ((w_img_h - w_fil_size) >> w_stride_log2) + L_ONE;
    assign w_fea_w_next = ((w_img_w - w_fil_size) >> w_stride_log2) + L_ONE;
    assign w_start      = (r_state == S_WAIT) && in_begin && w_cfg_legal;

    // A window is valid once the filter fits and its origin lies on the stride grid
    assign w_accept   = (r_state == S_ACTIVE) && (core_state == 2'd2) && in_valid;
    assign w_fil_m1   = r_fil - L_ONE;
    assign w_dx       = r_x - w_fil_m1;
    assign w_dy       = r_y - w_fil_m1;
    assign w_sl_mask  = (L_ONE << r_sl) - L_ONE;
    assign w_window   = (r_x >= w_fil_m1) && (r_y >= w_fil_m1) &&
                        ((w_dx & w_sl_mask) == '0) && ((w_dy & w_sl_mask) == '0);
    assign w_x_last   = (r_x == r_img_w - L_ONE);
    assign w_y_last   = (r_y == r_img_h - L_ONE);
    assign w_last_pix = w_x_last && w_y_last;

    assign w_beat       = (r_state == S_ACTIVE) && (core_state == 2'd3) && !r_wait_back;
    assign w_final_beat = w_beat && (r_ox == r_fea_w - L_ONE) && (r_oy == r_fea_h - L_ONE);

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_state     <= S_WAIT;
            r_img_h     <= '0;
            r_img_w     <= '0;
            r_fil       <= '0;
            r_sl        <= '0;
            r_fea_h     <= '0;
            r_fea_w     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_wait_back <= 1'b0;
            r_addr      <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (in_begin) begin
                        if (w_cfg_legal) begin
                            r_state     <= S_ACTIVE;
                            r_img_h     <= w_img_h;
                            r_img_w     <= w_img_w;
                            r_fil       <= w_fil_size;
                            r_sl        <= w_stride_log2;
                            r_fea_h     <= w_fea_h_next;
                            r_fea_w     <= w_fea_w_next;
                            r_x         <= '0;
                            r_y         <= '0;
                            r_ox        <= '0;
                            r_oy        <= '0;
                            r_wait_back <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (out_end) r_state <= S_WAIT;
                end
            endcase

            if (w_accept) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + L_ONE;
                end else begin
                    r_x <= r_x + L_ONE;
                end
            end

            if (w_beat) begin
                if (r_ox == r_fea_w - L_ONE) begin
                    r_ox <= '0;
                    r_oy <= (r_oy == r_fea_h - L_ONE) ? '0 : r_oy + L_ONE;
                end else begin
                    r_ox <= r_ox + L_ONE;
                end
                if (w_final_beat) r_wait_back <= 1'b1;
            end

            // Clearing wins over counting so the next phase always starts at address 0
            if (w_start || out_end || r_s0_last) begin
                r_addr <= '0;
            end else if ((r_s0_win || w_beat) && !r_wait_back) begin
                r_addr <= r_addr + F_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_s0_win   <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_ob    <= 1'b0;
            r_we_pipe  <= '0;
            r_rst_pipe <= '0;
            r_ob_pipe  <= '0;
            r_oe_pipe  <= '0;
            r_fin_pipe <= '0;
            out_valid  <= 1'b0;
            out_end    <= 1'b0;
            for (int k = 0; k < PDELAY; k++) r_addr_pipe[k] <= '0;
        end else begin
            r_s0_win   <= w_accept && w_window;
            r_s0_first <= first_input;
            r_s0_last  <= w_accept && w_last_pix;
            r_s0_ob    <= w_accept && w_last_pix && last_input;
            r_we_pipe  <= {r_we_pipe[PDELAY-1:1], r_s0_win};
            r_rst_pipe <= {r_rst_pipe[PDELAY-1:1], r_s0_win && r_s0_first};
            r_ob_pipe  <= {r_ob_pipe[PDELAY-1:1], r_s0_ob};
            r_oe_pipe  <= {r_oe_pipe[PDELAY-1:1], w_beat};
            r_fin_pipe <= {r_fin_pipe[PDELAY-1:1], w_final_beat};
            out_valid  <= r_oe_pipe[PDELAY];
            out_end    <= r_fin_pipe[PDELAY];
            r_addr_pipe[0] <= r_addr;
            for (int k = 1; k < PDELAY; k++) r_addr_pipe[k] <= r_addr_pipe[k-1];
        end
    end

    assign mem_feat_we      = r_we_pipe[PDELAY];
    assign mem_feat_rst     = r_rst_pipe[PDELAY];
    assign out_begin        = r_ob_pipe[PDELAY];
    assign conv_oe          = r_oe_pipe[PDELAY];
    assign mem_feat_addr    = r_addr_pipe[PDELAY-2];
    assign mem_feat_addr_d1 = r_addr_pipe[PDELAY-1];
    assign w_fea_h          = r_fea_h;
    assign w_fea_w          = r_fea_w;

endmodule
